l2_req_arbiter: RTL and testbench



---
 rtl/l2_req_arbiter_pkg.sv | 40 ++++
 rtl/l2_req_arbiter_perf.sv | 47 ++++
 rtl/l2_req_arbiter.sv | 117 +++++++++++
 tb/tb_l2_req_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_req_arbiter_pkg.sv
// Shared types for the L2 request arbiter: line/word types, FSM state and grant owner.
package l2_req_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int LINE_W_DEF = 128;
  localparam int PERF_W     = 16;

  typedef logic [ADDR_W_DEF-1:0] lc3b_word;
  typedef logic [LINE_W_DEF-1:0] lc3b_block;

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    GAP
  } l2_arb_state_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_ICACHE,
    GRANT_DCACHE
  } arb_grant_t;

  // Round-robin pick: on a tie the master that did not win last time goes next.
  function automatic arb_grant_t pick_winner(input logic       i_req,
                                             input logic       d_req,
                                             input arb_grant_t last);
    arb_grant_t w;
    w = GRANT_NONE;
    if (i_req && d_req) begin
      w = (last == GRANT_ICACHE) ? GRANT_DCACHE : GRANT_ICACHE;
    end else if (i_req) begin
      w = GRANT_ICACHE;
    end else if (d_req) begin
      w = GRANT_DCACHE;
    end
    return w;
  endfunction

endpackage

// File: rtl/l2_req_arbiter_perf.sv
// Saturating grant/conflict counters for the L2 request arbiter.
// Only instantiated when L2_ARB_PERF_CNT_EN is defined.
module l2_arb_perf
  import l2_req_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_grant_i,
  input  logic              d_grant_i,
  input  logic              conflict_i,
  output logic [PERF_W-1:0] perf_i_grants_o,
  output logic [PERF_W-1:0] perf_d_grants_o,
  output logic [PERF_W-1:0] perf_conflicts_o
);

  logic [PERF_W-1:0] i_cnt_q, i_cnt_d;
  logic [PERF_W-1:0] d_cnt_q, d_cnt_d;
  logic [PERF_W-1:0] c_cnt_q, c_cnt_d;

  // Each counter steps by one on its event and sticks at all-ones.
  always_comb begin
    i_cnt_d = i_cnt_q;
    d_cnt_d = d_cnt_q;
    c_cnt_d = c_cnt_q;
    if (i_grant_i  && (i_cnt_q != '1)) i_cnt_d = i_cnt_q + 1'b1;
    if (d_grant_i  && (d_cnt_q != '1)) d_cnt_d = d_cnt_q + 1'b1;
    if (conflict_i && (c_cnt_q != '1)) c_cnt_d = c_cnt_q + 1'b1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_cnt_q <= '0;
      d_cnt_q <= '0;
      c_cnt_q <= '0;
    end else begin
      i_cnt_q <= i_cnt_d;
      d_cnt_q <= d_cnt_d;
      c_cnt_q <= c_cnt_d;
    end
  end

  assign perf_i_grants_o  = i_cnt_q;
  assign perf_d_grants_o  = d_cnt_q;
  assign perf_conflicts_o = c_cnt_q;

endmodule

// File: rtl/l2_req_arbiter.sv
// Two-master (icache/dcache) arbiter onto the single origin channel.
// Round-robin on ties, one strobe-low GAP cycle after every transaction.
// Optional counters: define L2_ARB_PERF_CNT_EN to add perf_* outputs.
module l2_req_arbiter
  import l2_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_strobe,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_strobe,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              orig_strobe,
  output logic              orig_write,
  output logic [ADDR_W-1:0] orig_addr,
  output logic [LINE_W-1:0] orig_wdata,
  input  logic [LINE_W-1:0] orig_rdata,
  input  logic              orig_resp
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_i_grants,
  output logic [PERF_W-1:0] perf_d_grants,
  output logic [PERF_W-1:0] perf_conflicts
`endif
);

  l2_arb_state_t state_q, state_d;
  arb_grant_t    last_grant_q, last_grant_d;
  arb_grant_t    winner;

  assign winner = pick_winner(i_strobe, d_strobe, last_grant_q);

  // State and round-robin history; reset leaves dcache as last winner so icache takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_DCACHE;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Next state: grants are only taken from IDLE and held until the origin responds.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (winner == GRANT_ICACHE) begin
          state_d      = GRANT_I;
          last_grant_d = GRANT_ICACHE;
        end else if (winner == GRANT_DCACHE) begin
          state_d      = GRANT_D;
          last_grant_d = GRANT_DCACHE;
        end
      end
      GRANT_I, GRANT_D: begin
        if (orig_resp) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output muxes: pure pass-through of the granted master, everything quiet otherwise.
  always_comb begin
    orig_strobe = 1'b0;
    orig_write  = 1'b0;
    orig_addr   = '0;
    orig_wdata  = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    unique case (state_q)
      GRANT_I: begin
        orig_strobe = 1'b1;
        orig_addr   = i_addr;
        i_resp      = orig_resp;
      end
      GRANT_D: begin
        orig_strobe = 1'b1;
        orig_write  = d_write;
        orig_addr   = d_addr;
        orig_wdata  = d_wdata;
        d_resp      = orig_resp;
      end
      default: begin
      end
    endcase
  end

  assign i_rdata = orig_rdata;
  assign d_rdata = orig_rdata;

`ifdef L2_ARB_PERF_CNT_EN
  l2_arb_perf u_perf (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_grant_i        ((state_q == IDLE) && (state_d == GRANT_I)),
    .d_grant_i        ((state_q == IDLE) && (state_d == GRANT_D)),
    .conflict_i       ((state_q == IDLE) && i_strobe && d_strobe),
    .perf_i_grants_o  (perf_i_grants),
    .perf_d_grants_o  (perf_d_grants),
    .perf_conflicts_o (perf_conflicts)
  );
`endif

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: vector table, directed corner
// sequences, and randomized traffic against a transaction-level model.
module tb_l2_req_arbiter;

  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_strobe;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_strobe;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          orig_strobe;
  logic          orig_write;
  logic [AW-1:0] orig_addr;
  logic [LW-1:0] orig_wdata;
  logic [LW-1:0] orig_rdata;
  logic          orig_resp;
`ifdef L2_ARB_PERF_CNT_EN
  logic [15:0]   perf_i_grants;
  logic [15:0]   perf_d_grants;
  logic [15:0]   perf_conflicts;
`endif

  int testsRun = 0;
  int testsFailed = 0;

  l2_req_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_strobe    (i_strobe),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_strobe    (d_strobe),
    .d_write     (d_write),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .orig_strobe (orig_strobe),
    .orig_write  (orig_write),
    .orig_addr   (orig_addr),
    .orig_wdata  (orig_wdata),
    .orig_rdata  (orig_rdata),
    .orig_resp   (orig_resp)
`ifdef L2_ARB_PERF_CNT_EN
    ,
    .perf_i_grants  (perf_i_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it and reports a failure line on mismatch
  task automatic checkOutput(input string name, input logic [LW-1:0] actual, input logic [LW-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Drive the control inputs for the coming cycle
  task automatic applyStimulus(input logic iS, input logic dS, input logic dW, input logic resp);
    i_strobe  = iS;
    d_strobe  = dS;
    d_write   = dW;
    orig_resp = resp;
  endtask

  // Assert reset for two cycles, check the quiet outputs, release just after an edge
  task automatic applyReset();
    rst_n      = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    i_addr     = '0;
    d_addr     = '0;
    d_wdata    = '0;
    orig_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstStrobe", orig_strobe, 0);
    checkOutput("rstWrite",  orig_write,  0);
    checkOutput("rstAddr",   orig_addr,   0);
    checkOutput("rstWdata",  orig_wdata,  0);
    checkOutput("rstIResp",  i_resp,      0);
    checkOutput("rstDResp",  d_resp,      0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        iS;
    logic        dS;
    logic        dW;
    logic        resp;
    logic        eStrobe;
    logic        eWrite;
    logic        eIResp;
    logic        eDResp;
    logic [15:0] eAddr;
  } vecT;

  vecT vecs[18];

  // Transaction-level reference: who owns the channel, whether we are cooling down, who won last
  int mOwner;   // 0 nobody, 1 icache, 2 dcache
  bit mGap;
  int mLast;    // 1 icache, 2 dcache

  initial begin
    int lowRun;
    int nGrants;
    int grantee;
    bit prevHigh;
    logic [LW-1:0] expLine;

    // Cycle-by-cycle vector table starting from reset (IDLE, dcache last)
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[3]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 16'h1230};
    vecs[4]  = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'h1230};
    vecs[5]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[6]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[7]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0, 16'h4560};
    vecs[8]  = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1, 16'h4560};
    vecs[9]  = '{1'b1,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[11] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 16'h4560};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 16'h4560};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1, 16'h4560};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0, 16'h1230};
    vecs[17] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 16'h0000};

    applyReset();

    // Table: drive each row, check at the falling edge, advance one cycle
    i_addr  = 16'h1230;
    d_addr  = 16'h4560;
    d_wdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    for (int v = 0; v < 18; v++) begin
      applyStimulus(vecs[v].iS, vecs[v].dS, vecs[v].dW, vecs[v].resp);
      @(negedge clk);
      checkOutput($sformatf("vec%0dStrobe", v), orig_strobe, vecs[v].eStrobe);
      checkOutput($sformatf("vec%0dIResp", v),  i_resp,      vecs[v].eIResp);
      checkOutput($sformatf("vec%0dDResp", v),  d_resp,      vecs[v].eDResp);
      if (vecs[v].eStrobe) begin
        checkOutput($sformatf("vec%0dWrite", v), orig_write, vecs[v].eWrite);
        checkOutput($sformatf("vec%0dAddr", v),  orig_addr,  vecs[v].eAddr);
      end
      @(posedge clk);
      #1;
    end

    // icache read alone, origin answers after three wait cycles
    i_addr     = 16'h1230;
    orig_rdata = 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("iOnlyIdleStrobe", orig_strobe, 0);
    @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      checkOutput("iOnlyStrobe", orig_strobe, 1);
      checkOutput("iOnlyAddr",   orig_addr,   16'h1230);
      checkOutput("iOnlyWrite",  orig_write,  0);
      checkOutput("iOnlyWaitIResp", i_resp,   0);
      checkOutput("iOnlyDResp",  d_resp,      0);
      @(posedge clk);
      #1;
    end
    orig_resp = 1'b1;
    @(negedge clk);
    checkOutput("iOnlyIResp", i_resp,  1);
    checkOutput("iOnlyRdata", i_rdata, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5);
    checkOutput("iOnlyDRespAtResp", d_resp, 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("iOnlyGapStrobe", orig_strobe, 0);
    checkOutput("iOnlyRespPulse", i_resp, 0);
    @(posedge clk);
    #1;

    // dcache writeback alone
    d_addr  = 16'h4560;
    d_wdata = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("dWbIdleStrobe", orig_strobe, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("dWbStrobe", orig_strobe, 1);
    checkOutput("dWbWrite",  orig_write,  1);
    checkOutput("dWbAddr",   orig_addr,   16'h4560);
    checkOutput("dWbWdata",  orig_wdata,  128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF);
    checkOutput("dWbWaitDResp", d_resp,   0);
    @(posedge clk);
    #1;
    orig_resp = 1'b1;
    @(negedge clk);
    checkOutput("dWbDResp", d_resp, 1);
    checkOutput("dWbIResp", i_resp, 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("dWbGapStrobe", orig_strobe, 0);
    checkOutput("dWbGapDResp",  d_resp,      0);
    @(posedge clk);
    #1;

    // Both masters held after reset: expect I, D, I, D, I, D with >=2 low cycles between
    applyReset();
    i_addr = 16'h1111;
    d_addr = 16'h2222;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    lowRun   = 0;
    nGrants  = 0;
    prevHigh = 1'b0;
    for (int cyc = 0; cyc < 200 && nGrants < 6; cyc++) begin
      @(negedge clk);
      if (orig_strobe && !prevHigh) begin
        grantee = (orig_addr == 16'h1111) ? 1 : 2;
        checkOutput($sformatf("tieOrder%0d", nGrants), grantee, (nGrants % 2 == 0) ? 1 : 2);
        if (nGrants > 0) checkOutput($sformatf("tieLowGap%0d", nGrants), (lowRun >= 2), 1);
        nGrants++;
      end
      if (orig_strobe) lowRun = 0;
      else lowRun++;
      prevHigh = orig_strobe;
      @(posedge clk);
      #1;
      orig_resp = orig_strobe;
    end
    checkOutput("tieGrantCount", nGrants, 6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
`ifdef L2_ARB_PERF_CNT_EN
    checkOutput("perfIGrants", perf_i_grants, 3);
    checkOutput("perfDGrants", perf_d_grants, 3);
    checkOutput("perfConflictsAtLeast3", (perf_conflicts >= 3), 1);
`endif

    // Reset while dcache is granted and waiting: strobe drops at once, no resp
    applyReset();
    i_addr = 16'h1230;
    d_addr = 16'h4560;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abortIdle", orig_strobe, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("abortGranted", orig_strobe, 1);
    #2;
    orig_resp = 1'b1;
    rst_n     = 1'b0;
    #1;
    checkOutput("abortStrobeDrop", orig_strobe, 0);
    checkOutput("abortNoDResp",    d_resp,      0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abortReleaseIdle", orig_strobe, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("abortTieStrobe", orig_strobe, 1);
    checkOutput("abortTieWinnerI", orig_addr, 16'h1230);

    // Randomized traffic against the reference model
    applyReset();
    mOwner = 0;
    mGap   = 1'b0;
    mLast  = 2;
    for (int c = 0; c < 1500; c++) begin
      i_strobe   = ($urandom_range(0, 2) != 0);
      d_strobe   = ($urandom_range(0, 2) != 0);
      d_write    = $urandom_range(0, 1);
      orig_resp  = ($urandom_range(0, 3) == 0);
      i_addr     = AW'($urandom);
      d_addr     = AW'($urandom);
      d_wdata    = {$urandom, $urandom, $urandom, $urandom};
      orig_rdata = {$urandom, $urandom, $urandom, $urandom};
      expLine    = orig_rdata;
      @(negedge clk);
      checkOutput("rndStrobe", orig_strobe, (mOwner != 0));
      checkOutput("rndIResp",  i_resp, (mOwner == 1) && orig_resp);
      checkOutput("rndDResp",  d_resp, (mOwner == 2) && orig_resp);
      if (mOwner == 1) begin
        checkOutput("rndIAddr",  orig_addr,  i_addr);
        checkOutput("rndIWrite", orig_write, 0);
        if (orig_resp) checkOutput("rndIRdata", i_rdata, expLine);
      end else if (mOwner == 2) begin
        checkOutput("rndDAddr",  orig_addr,  d_addr);
        checkOutput("rndDWrite", orig_write, d_write);
        checkOutput("rndDWdata", orig_wdata, d_wdata);
        if (orig_resp) checkOutput("rndDRdata", d_rdata, expLine);
      end
      @(posedge clk);
      // Advance the model with what the edge saw
      if (mOwner != 0) begin
        if (orig_resp) begin
          mOwner = 0;
          mGap   = 1'b1;
        end
      end else if (mGap) begin
        mGap = 1'b0;
      end else if (i_strobe && d_strobe) begin
        mOwner = (mLast == 1) ? 2 : 1;
        mLast  = mOwner;
      end else if (i_strobe) begin
        mOwner = 1;
        mLast  = 1;
      end else if (d_strobe) begin
        mOwner = 2;
        mLast  = 2;
      end
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
